// File: rtl/xiphos_serial_pkg.sv
// rtl/xiphos_serial_pkg.sv - shared types and helpers for the serial parity link
package xiphos_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic RX_IDLE_LEVEL = 1'b1;

    // XOR of the low n bits of v; the transmitter uses the same definition.
    function automatic logic xor_reduce(logic [15:0] v, int n);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < n) r = r ^ v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/parity_frame_rx_bit_sync.sv
// rtl/parity_frame_rx_bit_sync.sv - two-flop synchronizer with selectable reset level
module bit_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial receiver and XOR-parity checker for start/data/parity/stop frames
module parity_frame_rx
    import xiphos_serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic             ODD      = (PARITY_ODD != 0);

    rx_state_t         state, state_n;
    logic              rxs;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              acc;
    logic              perr;
    logic [DATA_W-1:0] shreg;
    logic              half_tick;
    logic              bit_end;

    bit_sync #(.RST_VAL(RX_IDLE_LEVEL)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    assign half_tick = (cnt == CNT_HALF);
    assign bit_end   = (cnt == CNT_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!rxs) state_n = START;
            START:   if (half_tick) state_n = rxs ? IDLE : DATA;
            DATA:    if (bit_end && idx == IDX_LAST) state_n = PARITY;
            PARITY:  if (bit_end) state_n = STOP;
            STOP:    if (bit_end) state_n = rxs ? IDLE : BREAK;
            BREAK:   if (rxs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: after the half-bit start check, every sample lands one full bit later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            acc        <= 1'b0;
            perr       <= 1'b0;
            shreg      <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                START: begin
                    if (half_tick) begin
                        cnt <= '0;
                        idx <= '0;
                        acc <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt        <= '0;
                        shreg[idx] <= rxs;
                        acc        <= acc ^ rxs;
                        if (idx != IDX_LAST) idx <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt  <= '0;
                        perr <= acc ^ rxs ^ ODD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt        <= '0;
                        data_out   <= shreg;
                        parity_err <= perr;
                        frame_err  <= ~rxs;
                        valid      <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb/tb_parity_frame_rx.sv - scoreboard bench for parity_frame_rx (even and odd parity instances)
module tb_parity_frame_rx;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out, data_out_o;
    logic       valid, valid_o;
    logic       parity_err, parity_err_o;
    logic       frame_err, frame_err_o;
    logic       busy, busy_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   vcount = 0;
    int   vtimes[$];
    exp_t q_even[$];
    exp_t q_odd[$];
    exp_t ee, eo;

    parity_frame_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    parity_frame_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out_o),
        .valid      (valid_o),
        .parity_err (parity_err_o),
        .frame_err  (frame_err_o),
        .busy       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            vcount++;
            vtimes.push_back(cyc);
            if (q_even.size() == 0) begin
                check("even_spurious_valid", 1, 0);
            end else begin
                ee = q_even.pop_front();
                check("even_data", data_out, ee.data);
                check("even_perr", parity_err, ee.perr);
                check("even_ferr", frame_err, ee.ferr);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_o) begin
            if (q_odd.size() == 0) begin
                check("odd_spurious_valid", 1, 0);
            end else begin
                eo = q_odd.pop_front();
                check("odd_data", data_out_o, eo.data);
                check("odd_perr", parity_err_o, eo.perr);
                check("odd_ferr", frame_err_o, eo.ferr);
            end
        end
    end

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 rx = b;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        exp_t e;
        e.data = d;
        e.ferr = ~stop;
        e.perr = (^d) ^ par;
        q_even.push_back(e);
        e.perr = ~((^d) ^ par);
        q_odd.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q_even.size() != 0 || q_odd.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, q_even.size() + q_odd.size(), 0);
    endtask

    initial begin
        int v0;
        int n;
        int t0;
        logic busy_seen;
        logic [7:0] dprev;

        // Reset with RX toggling
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1 rx = ~rx;
        end
        @(negedge clk);
        check("rst_data", data_out, 0);
        check("rst_valid", valid, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rx = 1'b1;
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            busy_seen = busy_seen | busy | busy_o;
        end
        check("idle_busy", busy_seen, 0);

        // Good frame, then a wrong-parity frame
        send_frame(8'hA5, 1'b0, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drain("drain_a5");
        send_frame(8'h07, 1'b0, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drain("drain_07");

        // Stop bit low followed by a long break
        v0 = vcount;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (10 * CPB) @(posedge clk);
        check("break_busy_low", busy, 1);
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("break_busy_hold", busy, 1);
        @(posedge clk);
        @(negedge clk);
        check("break_busy_release", busy, 0);
        repeat (20) @(negedge clk);
        drain("drain_3c");
        check("break_valid_count", vcount - v0, 1);

        // One-cycle glitch while idle
        dprev = data_out;
        v0 = vcount;
        @(posedge clk);
        #1 rx = 1'b0;
        @(posedge clk);
        #1 rx = 1'b1;
        n = 0;
        while (!busy && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("glitch_busy_rise", busy, 1);
        repeat (10) @(negedge clk);
        check("glitch_busy_fall", busy, 0);
        check("glitch_no_valid", vcount - v0, 0);
        check("glitch_data_hold", data_out, dprev);

        // Back-to-back frames with no idle bit
        t0 = vtimes.size();
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'hFE, 1'b1, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drain("drain_b2b");
        check("b2b_valid_count", vtimes.size() - t0, 2);
        if (vtimes.size() - t0 == 2) check("b2b_spacing", vtimes[t0 + 1] - vtimes[t0], 11 * CPB);

        // Reset in the middle of a third frame's data bits
        v0 = vcount;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_data", data_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_perr", parity_err, 0);
        check("midrst_ferr", frame_err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check("midrst_no_valid", vcount - v0, 0);
        check("midrst_idle", busy, 0);
        check("final_queues", q_even.size() + q_odd.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
